// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port system RAM (CPU vs DMA/loader).
// One access at a time; registered RAM strobes, acknowledges and read data.
module mem_port_arbiter #(
    parameter int AW     = 9,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e        state_q;
    logic          we_q;
    logic [1:0]    cnt_q;
    logic          owner_q;
    logic          busy_q;
    logic          cpu_ack_q, dma_ack_q;
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          ram_we_q;

    // On a tie the requester that did not own the last grant wins.
    logic          grant_dma;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign grant_dma = dma_req && (!cpu_req || !owner_q);
    assign sel_we    = grant_dma ? dma_we    : cpu_we;
    assign sel_addr  = grant_dma ? dma_addr  : cpu_addr;
    assign sel_wdata = grant_dma ? dma_wdata : cpu_wdata;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            cnt_q       <= 2'd0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            ram_we_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner_q     <= grant_dma;
                        we_q        <= sel_we;
                        ram_addr_q  <= sel_addr;
                        ram_wdata_q <= sel_wdata;
                        ram_we_q    <= sel_we;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        cpu_ack_q <= !owner_q;
                        dma_ack_q <= owner_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q   <= 2'(RD_LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        if (owner_q) dma_rdata_q <= ram_rdata;
                        else         cpu_rdata_q <= ram_rdata;
                        cpu_ack_q <= !owner_q;
                        dma_ack_q <= owner_q;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1 with a RAM model,
// one at RD_LAT=3 with a fixed-content read model for the latency sweep.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;

    logic        cpu_req, cpu_we, cpu_ack;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [8:0]  dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we, busy, owner;

    logic        x_dma_req, x_dma_we, x_dma_ack, x_cpu_ack;
    logic [8:0]  x_dma_addr;
    logic [31:0] x_dma_wdata, x_dma_rdata, x_cpu_rdata;
    logic [8:0]  x_ram_addr;
    logic [31:0] x_ram_wdata, x_ram_rdata;
    logic        x_ram_we, x_busy, x_owner;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.AW(9), .DW(32), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.AW(9), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(9'h0), .cpu_wdata(32'h0),
        .cpu_ack(x_cpu_ack), .cpu_rdata(x_cpu_rdata),
        .dma_req(x_dma_req), .dma_we(x_dma_we), .dma_addr(x_dma_addr), .dma_wdata(x_dma_wdata),
        .dma_ack(x_dma_ack), .dma_rdata(x_dma_rdata),
        .ram_addr(x_ram_addr), .ram_wdata(x_ram_wdata), .ram_we(x_ram_we), .ram_rdata(x_ram_rdata),
        .busy(x_busy), .owner(x_owner)
    );

    // Single-port RAM with one cycle of read latency.
    logic [31:0] mem1 [0:511];
    always @(posedge clk) begin
        if (ram_we) mem1[ram_addr] <= ram_wdata;
        ram_rdata <= mem1[ram_addr];
    end

    // Read-only RAM with three cycles of read latency; 0x1FF preloaded with 0x12345678.
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= (x_ram_addr == 9'h1FF) ? 32'h12345678 : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign x_ram_rdata = p3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        x_dma_req = 0; x_dma_we = 0; x_dma_addr = '0; x_dma_wdata = '0;

        // Reset values
        tick(); tick();
        check("rst cpu_ack",   cpu_ack,   0);
        check("rst dma_ack",   dma_ack,   0);
        check("rst cpu_rdata", cpu_rdata, 0);
        check("rst dma_rdata", dma_rdata, 0);
        check("rst ram_addr",  ram_addr,  0);
        check("rst ram_wdata", ram_wdata, 0);
        check("rst ram_we",    ram_we,    0);
        check("rst busy",      busy,      0);
        check("rst owner",     owner,     0);
        check("rst x_busy",    x_busy,    0);
        reset = 1'b0;

        // Tie-break and alternation: both write continuously for six transactions
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hAAAA0001;
        dma_req = 1; dma_we = 1; dma_addr = 9'h020; dma_wdata = 32'hBBBB0002;
        for (int k = 0; k < 6; k++) begin
            logic exp_dma;
            exp_dma = (k % 2 == 0);
            tick();
            check($sformatf("alt%0d owner", k),    owner,  exp_dma);
            check($sformatf("alt%0d busy", k),     busy,   1);
            check($sformatf("alt%0d ram_we", k),   ram_we, 1);
            check($sformatf("alt%0d ram_addr", k), ram_addr, exp_dma ? 32'h020 : 32'h010);
            check($sformatf("alt%0d ram_wdata", k), ram_wdata, exp_dma ? 32'hBBBB0002 : 32'hAAAA0001);
            check($sformatf("alt%0d early ack", k), {cpu_ack, dma_ack}, 0);
            tick();
            check($sformatf("alt%0d dma_ack", k),  dma_ack, exp_dma);
            check($sformatf("alt%0d cpu_ack", k),  cpu_ack, !exp_dma);
            check($sformatf("alt%0d we off", k),   ram_we, 0);
            tick();
            check($sformatf("alt%0d idle busy", k), busy, 0);
            check($sformatf("alt%0d ack clr", k),  {cpu_ack, dma_ack}, 0);
        end
        cpu_req = 0; dma_req = 0;
        tick();
        check("post-alt busy", busy, 0);

        // CPU write then read, DMA idle
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h005; cpu_wdata = 32'hDEADBEEF;
        check("wr c0 ram_we", ram_we, 0);
        tick();
        check("wr c1 ram_we",   ram_we,   1);
        check("wr c1 ram_addr", ram_addr, 32'h005);
        check("wr c1 wdata",    ram_wdata, 32'hDEADBEEF);
        check("wr c1 owner",    owner,    0);
        tick();
        check("wr c2 cpu_ack",  cpu_ack,  1);
        check("wr c2 ram_we",   ram_we,   0);
        check("wr c2 dma_ack",  dma_ack,  0);
        cpu_req = 0;
        tick();
        check("wr c3 cpu_ack",  cpu_ack,  0);
        check("wr c3 busy",     busy,     0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
        tick();
        check("rd c1 ram_we",   ram_we,   0);
        check("rd c1 busy",     busy,     1);
        check("rd c1 ram_addr", ram_addr, 32'h005);
        tick();
        check("rd c2 cpu_ack",  cpu_ack,  0);
        tick();
        check("rd c3 cpu_ack",  cpu_ack,  1);
        check("rd c3 cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd c3 dma_ack",  dma_ack,  0);
        check("rd c3 dma_rdata", dma_rdata, 0);
        cpu_req = 0;
        tick();
        check("rd c4 cpu_ack",  cpu_ack,  0);
        check("rd c4 rdata held", cpu_rdata, 32'hDEADBEEF);
        check("rd c4 busy",     busy,     0);

        // Dropped request: CPU read of 0x010 released during WAIT
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tick();
        tick();
        cpu_req = 0;
        check("drop c2 busy", busy, 1);
        tick();
        check("drop c3 cpu_ack", cpu_ack, 1);
        check("drop c3 rdata",   cpu_rdata, 32'hAAAA0001);
        tick();
        check("drop c4 cpu_ack", cpu_ack, 0);
        tick();
        check("drop c5 busy",    busy, 0);
        check("drop c5 cpu_ack", cpu_ack, 0);

        // Held request: req stays high one cycle past ack, second write granted
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h030; cpu_wdata = 32'h0C0C0C0C;
        tick();
        tick();
        check("held c2 cpu_ack", cpu_ack, 1);
        tick();
        check("held c3 busy", busy, 0);
        tick();
        cpu_req = 0;
        check("held c4 busy",   busy,   1);
        check("held c4 ram_we", ram_we, 1);
        tick();
        check("held c5 cpu_ack", cpu_ack, 1);
        tick();
        check("held c6 busy",    busy, 0);

        // Reset asserted during ISSUE of a CPU write to 0x005
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h005; cpu_wdata = 32'h0BADF00D;
        tick();
        check("rstm c1 ram_we", ram_we, 1);
        #2 reset = 1'b1;
        #1;
        check("rstm async ram_we", ram_we, 0);
        check("rstm async busy",   busy,   0);
        check("rstm async ack",    cpu_ack, 0);
        cpu_req = 0;
        tick();
        reset = 1'b0;
        tick();
        check("rstm post ack",   cpu_ack, 0);
        check("rstm post busy",  busy, 0);
        check("rstm post rdata", cpu_rdata, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
        tick(); tick(); tick();
        check("rstm rd ack",   cpu_ack, 1);
        check("rstm rd old",   cpu_rdata, 32'hDEADBEEF);
        cpu_req = 0;
        tick();

        // Read latency sweep on the RD_LAT=3 instance
        x_dma_req = 1; x_dma_we = 0; x_dma_addr = 9'h1FF;
        tick();
        check("lat3 c1 owner",   x_owner, 1);
        check("lat3 c1 busy",    x_busy, 1);
        check("lat3 c1 addr",    x_ram_addr, 32'h1FF);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("lat3 c%0d addr", c), x_ram_addr, 32'h1FF);
            check($sformatf("lat3 c%0d ack", c),  x_dma_ack, 0);
            check($sformatf("lat3 c%0d we", c),   x_ram_we, 0);
        end
        tick();
        check("lat3 c5 ack",   x_dma_ack, 1);
        check("lat3 c5 rdata", x_dma_rdata, 32'h12345678);
        check("lat3 c5 cpu_ack", x_cpu_ack, 0);
        x_dma_req = 0;
        tick();
        check("lat3 c6 ack",   x_dma_ack, 0);
        check("lat3 c6 cpu_rdata", x_cpu_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port system RAM between two requesters: the CPU control path (MAR/MDR read/write) and a DMA/program-loader port. It sits between the control unit's memory strobes and the RAM macro. It serialises accesses, applies round-robin priority on contention, and returns a one-cycle acknowledge with registered read data to whichever requester owned the access.

## Interface
Parameters
- AW, 9: RAM address width.
- DW, 32: data width.
- RD_LAT, 1: RAM read latency in cycles, from address sampled to ram_rdata valid. Legal values 1..3.

Ports
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  registered read data; valid when cpu_ack is high, held afterwards.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same widths and meaning as the cpu_* ports, for the DMA/loader.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DW  RAM read data.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  0 = CPU, 1 = DMA; identifies the current or most recent grant.

## Operation
States: IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - No request: stay in IDLE.
  - One requester active: grant it.
  - Both active: grant the requester that is not `owner` (round-robin). After reset `owner` = 0, so in the first tie the DMA wins. The rule is applied consistently from then on.
  - On grant: latch the winner's we/addr/wdata into internal registers, set `owner`, and go to ISSUE.
- **ISSUE** (1 cycle)
  - Drive ram_addr and ram_wdata from the latched values.
  - ram_we = latched we; this is the only state in which ram_we can be high.
  - Write: go to DONE.
  - Read: load the wait counter with RD_LAT and go to WAIT.
- **WAIT**
  - Hold ram_addr and decrement the counter.
  - When the counter reaches 1, capture ram_rdata into the owner's rdata register on that edge and go to DONE.
  - The non-owner's rdata register is never modified.
- **DONE** (1 cycle)
  - Assert the owner's ack; the other ack stays 0.
  - Go to IDLE.
- Request inputs are ignored outside IDLE. A requester that drops req mid-transaction still gets its access completed and acked.
- A requester must deassert req on the edge where it samples ack high. A req still high in the following IDLE cycle is treated as a new request.
- Outside ISSUE/WAIT, ram_addr and ram_wdata hold their last values; ram_we = 0.
- Reset values: state IDLE, cpu_ack = dma_ack = 0, cpu_rdata = dma_rdata = 0, ram_addr = 0, ram_wdata = 0, ram_we = 0, busy = 0, owner = 0, counter = 0.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; ram_we drops asynchronously.
  - No ack is issued and the latched request is discarded.
  - The requester must re-request after reset is released.

## Timing
- Cycle 0 = the IDLE cycle in which req is sampled high.
- Write: ISSUE at cycle 1 (ram_we high), ack at cycle 2. Req-to-ack = 2 cycles.
- Read: ISSUE at cycle 1, WAIT at cycles 2..1+RD_LAT, ack at cycle 2+RD_LAT. With RD_LAT = 1, ack is at cycle 3.
- Back-to-back: the next grant is made in the IDLE cycle after DONE.
  - Maximum throughput: one write per 3 cycles, one read per RD_LAT+3 cycles.
- Under continuous contention, grants strictly alternate; neither requester waits more than one foreign transaction.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **CPU write then read:** CPU write 0xDEADBEEF to address 0x05 with the DMA idle.
  - ram_we high for exactly one cycle at cycle 1 with ram_addr = 0x05; cpu_ack at cycle 2.
  - CPU then reads 0x05: cpu_rdata = 0xDEADBEEF with cpu_ack at cycle 3 (RD_LAT = 1); dma_ack stays 0 and dma_rdata stays 0.
- **Tie-break and alternation:** first cycle after reset, cpu_req and dma_req rise together, both as writes.
  - DMA is granted first (owner = 1, dma_ack at cycle 2).
  - CPU is granted next (owner = 0, cpu_ack at cycle 5).
  - With both held continuously for 6 transactions, grants alternate DMA, CPU, DMA, CPU, DMA, CPU.
- **Read latency sweep:** RD_LAT = 3, DMA reads address 0x1FF preloaded with 0x12345678.
  - dma_ack at cycle 5 with dma_rdata = 0x12345678; ram_addr held at 0x1FF during cycles 1–4.
- **Dropped request:** CPU read issued, then cpu_req dropped during WAIT.
  - Access completes and cpu_ack pulses once; no second transaction starts.
- **Reset mid-access:** assert reset during the ISSUE cycle of a CPU write.
  - ram_we falls without waiting for a clock edge, no ack is issued, and busy = 0.
  - The RAM location holds its old value if the reset arrived before the write edge.
- **Held request:** CPU holds req high one cycle past ack.
  - A second CPU access is granted in that IDLE cycle (busy goes high again at the next cycle).
